// File: rtl/trace_reader.sv
// rtl/trace_reader.sv - raster-locked scanout of a 160-sample buffer as a connected-line trace
// Also owns the ping-pong bank handshake with the capture writer; banks swap only in vertical blank.
module trace_reader #(
   parameter int Y_TOP       = 112,
   parameter int HOLD_FRAMES = 1
) (
   input  logic       clk_vga,
   input  logic       reset,
   input  logic [9:0] CounterX,
   input  logic [9:0] CounterY,
   input  logic       inDisplayArea,
   input  logic       vsync_start,
   input  logic       fill_done,
   input  logic [7:0] rd_data,
   output logic [7:0] rd_addr,
   output logic       rd_bank,
   output logic       fill_enable,
   output logic       pixel_on
);

   localparam logic [9:0] LP_ROW_BOT = 10'(Y_TOP + 255);
   localparam logic [4:0] LP_HOLD    = 5'(HOLD_FRAMES);

   generate
      if (Y_TOP < 0 || Y_TOP + 255 > 479) begin : g_bad_y_top
         $error("trace_reader: Y_TOP + 255 must lie within the visible rows 0..479");
      end
      if (HOLD_FRAMES < 1 || HOLD_FRAMES > 15) begin : g_bad_hold
         $error("trace_reader: HOLD_FRAMES must be in 1..15");
      end
   endgenerate

   typedef enum logic {ST_FILLING, ST_FULL} bank_state_t;

   logic [7:0]  r_rd_addr;
   logic [9:0]  r_y1, r_y2;
   logic        r_de1, r_de2;
   logic [1:0]  r_sub1, r_sub2;
   logic [7:0]  r_addr2;
   logic [7:0]  r_prev;
   logic        r_pixel_on;

   bank_state_t r_state;
   logic [3:0]  r_frame_cnt;
   logic        r_rd_bank;
   logic        r_fill_enable;
   logic        r_fill_done_q;

   logic [7:0]  w_addr_next;
   logic [7:0]  w_prev_eff;
   logic [9:0]  w_r_cur, w_r_prev, w_lo, w_hi;
   logic        w_fill_edge;
   logic [4:0]  w_cnt_inc;
   logic [3:0]  w_cnt_sat;

   assign w_addr_next = (CounterX >= 10'd640) ? 8'd159 : CounterX[9:2];

   // Sample 0 pairs with itself so no segment is drawn back to the previous line's last sample.
   assign w_prev_eff = (r_addr2 == 8'd0) ? rd_data : r_prev;
   assign w_r_cur    = LP_ROW_BOT - {2'b00, rd_data};
   assign w_r_prev   = LP_ROW_BOT - {2'b00, w_prev_eff};
   assign w_lo       = (w_r_cur < w_r_prev) ? w_r_cur  : w_r_prev;
   assign w_hi       = (w_r_cur < w_r_prev) ? w_r_prev : w_r_cur;

   assign w_fill_edge = fill_done & ~r_fill_done_q;
   assign w_cnt_inc   = {1'b0, r_frame_cnt} + 5'd1;
   assign w_cnt_sat   = (r_frame_cnt == 4'd15) ? 4'd15 : w_cnt_inc[3:0];

   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         r_rd_addr  <= 8'd0;
         r_y1       <= 10'd0;
         r_de1      <= 1'b0;
         r_sub1     <= 2'd0;
         r_addr2    <= 8'd0;
         r_y2       <= 10'd0;
         r_de2      <= 1'b0;
         r_sub2     <= 2'd0;
         r_prev     <= 8'd0;
         r_pixel_on <= 1'b0;
      end else begin
         r_rd_addr  <= w_addr_next;
         r_y1       <= CounterY;
         r_de1      <= inDisplayArea;
         r_sub1     <= CounterX[1:0];
         r_addr2    <= r_rd_addr;
         r_y2       <= r_y1;
         r_de2      <= r_de1;
         r_sub2     <= r_sub1;
         r_pixel_on <= r_de2 && (r_y2 >= w_lo) && (r_y2 <= w_hi);
         if (r_de2 && (r_sub2 == 2'd3)) begin
            r_prev <= rd_data;
         end
      end
   end

   // fill_enable drops with entry to FULL but only rises one cycle after a swap,
   // so the writer never targets a bank that is still settling.
   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         r_state       <= ST_FILLING;
         r_frame_cnt   <= 4'd0;
         r_rd_bank     <= 1'b0;
         r_fill_enable <= 1'b1;
         r_fill_done_q <= 1'b0;
      end else begin
         r_fill_done_q <= fill_done;
         case (r_state)
            ST_FILLING: begin
               if (vsync_start) begin
                  r_frame_cnt <= w_cnt_sat;
               end
               if (w_fill_edge) begin
                  r_state       <= ST_FULL;
                  r_fill_enable <= 1'b0;
               end else begin
                  r_fill_enable <= 1'b1;
               end
            end
            ST_FULL: begin
               r_fill_enable <= 1'b0;
               if (vsync_start) begin
                  if (w_cnt_inc >= LP_HOLD) begin
                     r_rd_bank   <= ~r_rd_bank;
                     r_frame_cnt <= 4'd0;
                     r_state     <= ST_FILLING;
                  end else begin
                     r_frame_cnt <= w_cnt_sat;
                  end
               end
            end
         endcase
      end
   end

   assign rd_addr     = r_rd_addr;
   assign rd_bank     = r_rd_bank;
   assign fill_enable = r_fill_enable;
   assign pixel_on    = r_pixel_on;

endmodule

// File: tb/tb_trace_reader.sv
// tb/tb_trace_reader.sv - self-checking bench for trace_reader
// Two instances (HOLD_FRAMES 1 and 2) share raster stimulus; each reads its own synchronous RAM port.
module tb_trace_reader;

   localparam int Y_TOP = 112;

   logic       clk_vga = 1'b0;
   logic       reset;
   logic [9:0] CounterX;
   logic [9:0] CounterY;
   logic       inDisplayArea;
   logic       vsync_start;
   logic       fill_done;
   logic [7:0] rd_data     [2];
   logic [7:0] rd_addr     [2];
   logic       rd_bank     [2];
   logic       fill_enable [2];
   logic       pixel_on    [2];

   logic [7:0] mem [160];

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_prev;
   bit pe   [3];
   int pxx  [3];
   int ae;
   bit m_fdq;
   bit m_ready [2];
   int m_shown [2];
   int m_bank  [2];
   int m_fe    [2];
   int hold    [2];
   int cap     [640];

   typedef struct {
      int row;
      int col;
      bit exp;
   } vec_t;
   vec_t tbl [16];

   always #5 clk_vga = ~clk_vga;

   always @(posedge clk_vga) begin
      rd_data[0] <= mem[rd_addr[0]];
      rd_data[1] <= mem[rd_addr[1]];
   end

   trace_reader #(.Y_TOP(Y_TOP), .HOLD_FRAMES(1)) u_dut1 (
      .clk_vga(clk_vga), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
      .inDisplayArea(inDisplayArea), .vsync_start(vsync_start), .fill_done(fill_done),
      .rd_data(rd_data[0]), .rd_addr(rd_addr[0]), .rd_bank(rd_bank[0]),
      .fill_enable(fill_enable[0]), .pixel_on(pixel_on[0])
   );

   trace_reader #(.Y_TOP(Y_TOP), .HOLD_FRAMES(2)) u_dut2 (
      .clk_vga(clk_vga), .reset(reset), .CounterX(CounterX), .CounterY(CounterY),
      .inDisplayArea(inDisplayArea), .vsync_start(vsync_start), .fill_done(fill_done),
      .rd_data(rd_data[1]), .rd_addr(rd_addr[1]), .rd_bank(rd_bank[1]),
      .fill_enable(fill_enable[1]), .pixel_on(pixel_on[1])
   );

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_prev = 0;
      ae     = 0;
      m_fdq  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pe[i]  = 1'b0;
         pxx[i] = -1;
      end
      for (int i = 0; i < 2; i++) begin
         m_ready[i] = 1'b0;
         m_shown[i] = 0;
         m_bank[i]  = 0;
         m_fe[i]    = 1;
      end
   endtask

   // Pixel lights when its row lies between the rows of this column's sample and the previous one.
   task automatic model_px(input int x, input int y, input bit de, output bit e);
      int k, cur, p, rc, rp, lo, hi;
      k  = (x >= 640) ? 159 : x / 4;
      cur = int'(mem[k]);
      p  = (k == 0) ? cur : m_prev;
      rc = Y_TOP + 255 - cur;
      rp = Y_TOP + 255 - p;
      lo = (rc < rp) ? rc : rp;
      hi = (rc < rp) ? rp : rc;
      e  = de && (y >= lo) && (y <= hi);
      if (de && (x % 4) == 3) m_prev = cur;
   endtask

   task automatic model_bank(input bit vs, input bit fd);
      bit edge_fd, was_ready, swap;
      edge_fd = fd && !m_fdq;
      m_fdq   = fd;
      for (int i = 0; i < 2; i++) begin
         was_ready = m_ready[i];
         swap      = 1'b0;
         if (vs) begin
            if (was_ready && (m_shown[i] + 1 >= hold[i])) begin
               swap       = 1'b1;
               m_bank[i]  = 1 - m_bank[i];
               m_shown[i] = 0;
               m_ready[i] = 1'b0;
            end else begin
               m_shown[i] = (m_shown[i] >= 15) ? 15 : m_shown[i] + 1;
            end
         end
         if (!was_ready && edge_fd) m_ready[i] = 1'b1;
         m_fe[i] = (!m_ready[i] && !swap) ? 1 : 0;
      end
   endtask

   // Drive one raster position at a negedge, advance one clock, compare at the next negedge.
   task automatic step(input int x, input int y, input bit de, input bit vs, input bit fd);
      bit e;
      CounterX      = 10'(x);
      CounterY      = 10'(y);
      inDisplayArea = de;
      vsync_start   = vs;
      fill_done     = fd;
      model_px(x, y, de, e);
      pe[2]  = pe[1];  pe[1]  = pe[0];  pe[0]  = e;
      pxx[2] = pxx[1]; pxx[1] = pxx[0]; pxx[0] = de ? x : -1;
      ae = (x >= 640) ? 159 : x / 4;
      model_bank(vs, fd);
      @(posedge clk_vga);
      @(negedge clk_vga);
      for (int i = 0; i < 2; i++) begin
         check($sformatf("pixel_on%0d x=%0d y=%0d", i, pxx[2], y), int'(pixel_on[i]), int'(pe[2]));
         check($sformatf("rd_addr%0d", i), int'(rd_addr[i]), ae);
         check($sformatf("rd_bank%0d", i), int'(rd_bank[i]), m_bank[i]);
         check($sformatf("fill_enable%0d", i), int'(fill_enable[i]), m_fe[i]);
      end
      if (pxx[2] >= 0 && pxx[2] < 640) cap[pxx[2]] = int'(pixel_on[0]);
   endtask

   task automatic idle(input int n, input bit fd);
      for (int i = 0; i < n; i++) step(700, 500, 1'b0, 1'b0, fd);
   endtask

   task automatic run_line(input int y);
      for (int i = 0; i < 640; i++) cap[i] = -1;
      for (int x = 0; x < 660; x++) step(x, y, x < 640, 1'b0, 1'b0);
   endtask

   function automatic int lit_count(input int from);
      int n = 0;
      for (int i = from; i < 640; i++) if (cap[i] == 1) n++;
      return n;
   endfunction

   initial begin
      int rows_flat [8];
      int rows_step [9];
      int rx, ry;
      hold[0] = 1;
      hold[1] = 2;
      for (int i = 0; i < 160; i++) mem[i] = 8'(2 * i);
      reset = 1'b1;
      CounterX = 10'd700; CounterY = 10'd500;
      inDisplayArea = 1'b0; vsync_start = 1'b0; fill_done = 1'b0;
      model_reset();
      @(posedge clk_vga); @(posedge clk_vga); @(negedge clk_vga);
      for (int i = 0; i < 2; i++) begin
         check("reset rd_addr", int'(rd_addr[i]), 0);
         check("reset rd_bank", int'(rd_bank[i]), 0);
         check("reset fill_enable", int'(fill_enable[i]), 1);
         check("reset pixel_on", int'(pixel_on[i]), 0);
      end
      reset = 1'b0;

      // ramp buffer: address stepping right after reset, then a row crossing the ramp
      for (int x = 0; x < 16; x++) step(x, 200, 1'b1, 1'b0, 1'b0);
      idle(4, 1'b0);
      for (int x = 0; x < 40; x++) step(x, 362, 1'b1, 1'b0, 1'b0);
      idle(4, 1'b0);

      // flat trace at row 239
      for (int i = 0; i < 160; i++) mem[i] = 8'd128;
      rows_flat = '{238, 239, 240, 0, 111, 367, 368, 479};
      foreach (rows_flat[r]) begin
         run_line(rows_flat[r]);
         check($sformatf("flat lit count row %0d", rows_flat[r]), lit_count(0),
               (rows_flat[r] == 239) ? 640 : 0);
      end

      // step between samples 9 and 10; sample 159 far from line start
      idle(4, 1'b0);
      mem[9] = 8'd100; mem[10] = 8'd140; mem[159] = 8'd0;
      tbl[0]  = '{227, 40, 1'b1}; tbl[1]  = '{227, 43, 1'b1}; tbl[2]  = '{226, 40, 1'b0};
      tbl[3]  = '{267, 40, 1'b1}; tbl[4]  = '{268, 40, 1'b0}; tbl[5]  = '{250, 42, 1'b1};
      tbl[6]  = '{267, 39, 1'b1}; tbl[7]  = '{239, 39, 1'b1}; tbl[8]  = '{238, 39, 1'b0};
      tbl[9]  = '{240, 36, 1'b1}; tbl[10] = '{239, 44, 1'b1}; tbl[11] = '{227, 44, 1'b1};
      tbl[12] = '{226, 44, 1'b0}; tbl[13] = '{239, 0,  1'b1}; tbl[14] = '{300, 0,  1'b0};
      tbl[15] = '{300, 636, 1'b1};
      rows_step = '{226, 227, 238, 239, 240, 250, 267, 268, 300};
      foreach (rows_step[r]) begin
         run_line(rows_step[r]);
         for (int t = 0; t < 16; t++) begin
            if (tbl[t].row == rows_step[r])
               check($sformatf("step row %0d col %0d", tbl[t].row, tbl[t].col),
                     cap[tbl[t].col], int'(tbl[t].exp));
         end
      end

      // random raster positions, buffer contents and handshake traffic
      idle(4, 1'b0);
      for (int i = 0; i < 160; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int n = 0; n < 3000; n++) begin
         rx = int'($urandom_range(0, 799));
         ry = int'($urandom_range(0, 524));
         step(rx, ry, (rx < 640) && (ry < 480), $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0);
      end

      // bank handshake from a clean reset
      idle(2, 1'b0);
      reset = 1'b1;
      @(posedge clk_vga); @(negedge clk_vga);
      reset = 1'b0;
      model_reset();
      idle(5, 1'b0);
      step(700, 500, 1'b0, 1'b0, 1'b1);
      check("fill_enable drops after fill_done", int'(fill_enable[0]), 0);
      check("rd_bank held after fill_done", int'(rd_bank[0]), 0);
      idle(10, 1'b0);
      step(700, 500, 1'b0, 1'b1, 1'b0);
      check("rd_bank swaps after vsync", int'(rd_bank[0]), 1);
      check("fill_enable still low at swap", int'(fill_enable[0]), 0);
      check("hold2 no swap after one frame", int'(rd_bank[1]), 0);
      idle(1, 1'b0);
      check("fill_enable rises after swap", int'(fill_enable[0]), 1);
      idle(3, 1'b0);
      step(700, 500, 1'b0, 1'b1, 1'b0);
      check("hold2 swaps on second vsync", int'(rd_bank[1]), 1);
      idle(3, 1'b0);
      step(700, 500, 1'b0, 1'b1, 1'b0);
      idle(3, 1'b0);

      // same-cycle fill_done edge and vsync, then a retrigger attempt while FULL
      step(700, 500, 1'b0, 1'b1, 1'b1);
      check("same-cycle vsync does not swap", int'(rd_bank[1]), 1);
      check("same-cycle enters FULL", int'(fill_enable[1]), 0);
      idle(3, 1'b1);
      idle(1, 1'b0);
      idle(3, 1'b1);
      step(700, 500, 1'b0, 1'b1, 1'b1);
      check("hold2 swap after same-cycle", int'(rd_bank[1]), 0);
      idle(4, 1'b1);
      check("held fill_done does not retrigger", int'(fill_enable[1]), 1);
      idle(2, 1'b0);

      // async reset mid-line while FULL on bank 1
      if (m_bank[0] == 0) begin
         idle(1, 1'b1); idle(1, 1'b0);
         step(700, 500, 1'b0, 1'b1, 1'b0);
         idle(1, 1'b0);
      end
      idle(1, 1'b1); idle(1, 1'b0);
      check("pre-reset rd_bank", int'(rd_bank[0]), 1);
      check("pre-reset fill_enable", int'(fill_enable[0]), 0);
      for (int i = 0; i < 160; i++) mem[i] = 8'd128;
      idle(4, 1'b0);
      for (int i = 0; i < 640; i++) cap[i] = -1;
      for (int x = 0; x < 100; x++) step(x, 239, 1'b1, 1'b0, 1'b0);
      @(posedge clk_vga);
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("async reset rd_addr", int'(rd_addr[i]), 0);
         check("async reset rd_bank", int'(rd_bank[i]), 0);
         check("async reset fill_enable", int'(fill_enable[i]), 1);
         check("async reset pixel_on", int'(pixel_on[i]), 0);
      end
      model_reset();
      @(negedge clk_vga); @(negedge clk_vga);
      reset = 1'b0;
      for (int x = 100; x < 660; x++) step(x, 239, x < 640, 1'b0, 1'b0);
      check("scanout resumes after reset", lit_count(100), 540);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
